// File: rtl/tmp_seq_ctrl.sv
// Heat/cool actuator sequencer: registered FSM with minimum run time, rest lockout and config-error guard.
// Optional hysteresis exit band is enabled by defining TMP_SEQ_HYST_EN.
module tmp_seq_ctrl #(
  parameter int TW      = 17,
  parameter int CW      = 8,
  parameter int MIN_ON  = 16,
  parameter int MIN_OFF = 8,
  parameter int HYST    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [TW-1:0] temp,
  input  logic          temp_vld,
  input  logic [TW-1:0] low_thresh,
  input  logic [TW-1:0] high_thresh,
  output logic          heat,
  output logic          cool,
  output logic [1:0]    state,
  output logic          cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_HEAT = 2'b01,
    S_COOL = 2'b10,
    S_REST = 2'b11
  } state_t;

`ifdef TMP_SEQ_HYST_EN
  localparam int BAND = HYST;
`else
  localparam int BAND = 1;
`endif

  localparam logic [CW-1:0] MIN_ON_C     = CW'(MIN_ON);
  localparam logic [CW-1:0] MIN_OFF_LAST = CW'(MIN_OFF - 1);
  localparam logic [TW:0]   BAND_W       = (TW + 1)'(BAND);
  localparam logic [TW-1:0] BAND_T       = TW'(BAND);

  state_t        state_reg;
  logic          heat_reg;
  logic          cool_reg;
  logic          cfg_err_reg;
  logic [CW-1:0] run_cnt_reg;
  logic [CW-1:0] rest_cnt_reg;

  logic          cfg_err_next;
  logic          force_off;
  logic [TW:0]   heat_exit;
  logic [TW-1:0] cool_exit;
  logic          run_full;
  logic          heat_over;
  logic          heat_done;
  logic          cool_over;
  logic          cool_done;

  // Heat exit is one bit wider so a threshold near full scale cannot wrap.
  assign heat_exit    = {1'b0, low_thresh} + BAND_W;
  assign cool_exit    = (high_thresh >= BAND_T) ? (high_thresh - BAND_T) : '0;
  assign cfg_err_next = (low_thresh >= high_thresh);
  assign force_off    = !en || cfg_err_next;
  assign run_full     = (run_cnt_reg == MIN_ON_C);
  assign heat_over    = temp_vld && (temp >= high_thresh);
  assign heat_done    = temp_vld && ({1'b0, temp} >= heat_exit);
  assign cool_over    = temp_vld && (temp <= low_thresh);
  assign cool_done    = temp_vld && (temp <= cool_exit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      heat_reg     <= 1'b0;
      cool_reg     <= 1'b0;
      cfg_err_reg  <= 1'b0;
      run_cnt_reg  <= '0;
      rest_cnt_reg <= '0;
    end else begin
      cfg_err_reg <= cfg_err_next;
      case (state_reg)
        S_IDLE: begin
          if (!force_off && temp_vld) begin
            if (temp <= low_thresh) begin
              state_reg   <= S_HEAT;
              heat_reg    <= 1'b1;
              cool_reg    <= 1'b0;
              run_cnt_reg <= '0;
            end else if (temp >= high_thresh) begin
              state_reg   <= S_COOL;
              heat_reg    <= 1'b0;
              cool_reg    <= 1'b1;
              run_cnt_reg <= '0;
            end
          end
        end
        S_HEAT: begin
          if (force_off || heat_over || (run_full && heat_done)) begin
            state_reg    <= S_REST;
            heat_reg     <= 1'b0;
            cool_reg     <= 1'b0;
            rest_cnt_reg <= '0;
          end else if (!run_full) begin
            run_cnt_reg <= run_cnt_reg + 1'b1;
          end
        end
        S_COOL: begin
          if (force_off || cool_over || (run_full && cool_done)) begin
            state_reg    <= S_REST;
            heat_reg     <= 1'b0;
            cool_reg     <= 1'b0;
            rest_cnt_reg <= '0;
          end else if (!run_full) begin
            run_cnt_reg <= run_cnt_reg + 1'b1;
          end
        end
        S_REST: begin
          // Inputs are deliberately ignored until the lockout expires.
          if (rest_cnt_reg == MIN_OFF_LAST) begin
            state_reg <= S_IDLE;
          end else begin
            rest_cnt_reg <= rest_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          heat_reg  <= 1'b0;
          cool_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign heat    = heat_reg;
  assign cool    = cool_reg;
  assign state   = state_reg;
  assign cfg_err = cfg_err_reg;

endmodule
